// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of ALU and long-latency results onto
// the single register-file write port, plus a busy scoreboard for decode hazard stalls.
module rf_wb_scheduler #(
  parameter int MAX_LONG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  output logic        m_ready,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic [31:0] busy,
  output logic [2:0]  long_cnt
);

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_M = 1'b1;
  // Counter is widened internally for large MAX_LONG; the port exposes the low 3 bits.
  localparam int CNT_W = (MAX_LONG > 7) ? 5 : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LONG);

  logic              r_last;
  logic              r_wr_en;
  logic [4:0]        r_wr_rd;
  logic [31:0]       r_wr_data;
  logic              r_wr_src;
  logic [31:1]       r_busy;
  logic [CNT_W-1:0]  r_long_cnt;

  logic              w_a_grant;
  logic              w_m_grant;
  logic              w_xfer;
  logic [4:0]        w_sel_rd;
  logic [31:0]       w_sel_data;
  logic [31:0]       w_busy;
  logic              w_set;
  logic              w_clr;
  logic              w_hazard;

  assign w_busy = {r_busy, 1'b0};

  // Round-robin: a lone requester wins; on a tie the one that did not win last goes.
  always_comb begin
    w_a_grant  = !rst && a_valid && (!m_valid || (r_last == SRC_M));
    w_m_grant  = !rst && m_valid && (!a_valid || (r_last == SRC_A));
    w_xfer     = w_a_grant || w_m_grant;
    w_sel_rd   = w_m_grant ? m_rd : a_rd;
    w_sel_data = w_m_grant ? m_data : a_data;
  end

  always_comb begin
    w_hazard = ((issue_rs1 != 5'd0) && w_busy[issue_rs1]) ||
               ((issue_rs2 != 5'd0) && w_busy[issue_rs2]) ||
               ((issue_rd  != 5'd0) && w_busy[issue_rd])  ||
               (issue_long && (r_long_cnt == CNT_MAX));
    issue_stall = !rst && issue_valid && w_hazard;
  end

  assign w_set = issue_valid && !issue_stall && issue_long && (issue_rd != 5'd0);
  assign w_clr = r_wr_en && (r_wr_src == SRC_M) && w_busy[r_wr_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= SRC_M;
      r_wr_en   <= 1'b0;
      r_wr_rd   <= 5'd0;
      r_wr_data <= 32'd0;
      r_wr_src  <= SRC_A;
    end else if (w_xfer) begin
      r_last    <= w_m_grant ? SRC_M : SRC_A;
      r_wr_en   <= (w_sel_rd != 5'd0);
      r_wr_rd   <= w_sel_rd;
      r_wr_data <= w_sel_data;
      r_wr_src  <= w_m_grant ? SRC_M : SRC_A;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Clear lands on the same edge the register file stores the value, so no bypass is needed.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      always_ff @(posedge clk) begin
        if (rst) begin
          r_busy[gi] <= 1'b0;
        end else if (w_set && (issue_rd == 5'(gi))) begin
          r_busy[gi] <= 1'b1;
        end else if (w_clr && (r_wr_rd == 5'(gi))) begin
          r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_long_cnt <= '0;
    end else begin
      case ({w_set, w_clr})
        2'b10:   r_long_cnt <= r_long_cnt + 1'b1;
        2'b01:   r_long_cnt <= r_long_cnt - 1'b1;
        default: r_long_cnt <= r_long_cnt;
      endcase
    end
  end

  assign a_ready  = w_a_grant;
  assign m_ready  = w_m_grant;
  assign wr_en    = r_wr_en;
  assign wr_rd    = r_wr_rd;
  assign wr_data  = r_wr_data;
  assign busy     = w_busy;
  assign long_cnt = r_long_cnt[2:0];

endmodule
